// File: rtl/sort_mem_pkg.sv
// Shared definitions for the sort memory responder and the sorter controller:
// response codes, read/write FSM encodings and an address range helper.
package sort_mem_pkg;

    localparam logic RESP_OKAY = 1'b0;
    localparam logic RESP_ERR  = 1'b1;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_COMMIT = 2'd1,
        W_RESP   = 2'd2
    } wr_state_e;

    function automatic logic addr_in_range(input logic [31:0] addr, input int depth);
        return addr < $unsigned(depth);
    endfunction

endpackage

// File: rtl/sort_mem_array.sv
// DEPTH x DATA_WDTH register array: one synchronous write port, one
// combinational read port, cleared by the asynchronous reset.
module sort_mem_array
    import sort_mem_pkg::*;
#(
    parameter int ADDR_WDTH = 4,
    parameter int DATA_WDTH = 32,
    parameter int DEPTH     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [ADDR_WDTH-1:0] wr_addr,
    input  logic [DATA_WDTH-1:0] wr_data,
    input  logic [ADDR_WDTH-1:0] rd_addr,
    output logic [DATA_WDTH-1:0] rd_data
);

    logic [DATA_WDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Unimplemented words read as zero so an out-of-range index never reaches the array.
    always_comb begin
        rd_data = '0;
        if (addr_in_range(32'(rd_addr), DEPTH)) begin
            rd_data = mem_q[rd_addr];
        end
    end

endmodule

// File: rtl/sort_mem_responder.sv
// Memory responder for the insertion-sort datapath: independent read and write
// handshake FSMs in front of a word-addressed register array.
module sort_mem_responder
    import sort_mem_pkg::*;
#(
    parameter int ADDR_WDTH = 4,
    parameter int DATA_WDTH = 32,
    parameter int RESP_WDTH = 1,
    parameter int DEPTH     = 16,
    parameter int READ_LAT  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ar_valid,
    output logic                 ar_ready,
    input  logic [ADDR_WDTH-1:0] ar_address,
    output logic                 r_valid,
    input  logic                 r_ready,
    output logic [DATA_WDTH-1:0] r_data,
    output logic [RESP_WDTH-1:0] r_resp,
    input  logic                 aw_valid,
    output logic                 aw_ready,
    input  logic [ADDR_WDTH-1:0] write_addr,
    input  logic                 w_valid,
    output logic                 w_ready,
    input  logic [DATA_WDTH-1:0] write_data,
    output logic                 b_valid,
    input  logic                 b_ready,
    output logic [RESP_WDTH-1:0] b_resp
);

    rd_state_e            rd_state_q, rd_state_d;
    logic [ADDR_WDTH-1:0] rd_addr_q, rd_addr_d;
    logic [2:0]           rd_cnt_q, rd_cnt_d;
    logic                 ar_ready_q, ar_ready_d;
    logic                 r_valid_q, r_valid_d;
    logic [DATA_WDTH-1:0] r_data_q, r_data_d;
    logic [RESP_WDTH-1:0] r_resp_q, r_resp_d;

    wr_state_e            wr_state_q, wr_state_d;
    logic [ADDR_WDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WDTH-1:0] wr_data_q, wr_data_d;
    logic                 have_addr_q, have_addr_d;
    logic                 have_data_q, have_data_d;
    logic                 aw_ready_q, aw_ready_d;
    logic                 w_ready_q, w_ready_d;
    logic                 b_valid_q, b_valid_d;
    logic [RESP_WDTH-1:0] b_resp_q, b_resp_d;

    logic                 wr_en;
    logic                 wr_in_range;
    logic                 rd_in_range;
    logic [DATA_WDTH-1:0] arr_rd_data;

    assign rd_in_range = addr_in_range(32'(rd_addr_q), DEPTH);
    assign wr_in_range = addr_in_range(32'(wr_addr_q), DEPTH);

    sort_mem_array #(
        .ADDR_WDTH (ADDR_WDTH),
        .DATA_WDTH (DATA_WDTH),
        .DEPTH     (DEPTH)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr_q),
        .wr_data (wr_data_q),
        .rd_addr (rd_addr_q),
        .rd_data (arr_rd_data)
    );

    // R_WAIT always spends at least one cycle so that read data lands READ_LAT+1 edges after accept.
    always_comb begin
        rd_state_d = rd_state_q;
        rd_addr_d  = rd_addr_q;
        rd_cnt_d   = rd_cnt_q;
        ar_ready_d = ar_ready_q;
        r_valid_d  = r_valid_q;
        r_data_d   = r_data_q;
        r_resp_d   = r_resp_q;
        case (rd_state_q)
            R_IDLE: begin
                ar_ready_d = 1'b1;
                if (ar_valid && ar_ready_q) begin
                    rd_addr_d  = ar_address;
                    rd_cnt_d   = 3'(READ_LAT);
                    ar_ready_d = 1'b0;
                    rd_state_d = R_WAIT;
                end
            end
            R_WAIT: begin
                if (rd_cnt_q == 3'd0) begin
                    r_data_d   = rd_in_range ? arr_rd_data : '0;
                    r_resp_d   = rd_in_range ? RESP_WDTH'(RESP_OKAY) : RESP_WDTH'(RESP_ERR);
                    r_valid_d  = 1'b1;
                    rd_state_d = R_RESP;
                end else begin
                    rd_cnt_d = rd_cnt_q - 3'd1;
                end
            end
            R_RESP: begin
                if (r_ready) begin
                    r_valid_d  = 1'b0;
                    ar_ready_d = 1'b1;
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    // Address and data may arrive in either order; each ready drops once its half is held.
    always_comb begin
        wr_state_d  = wr_state_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        have_addr_d = have_addr_q;
        have_data_d = have_data_q;
        aw_ready_d  = aw_ready_q;
        w_ready_d   = w_ready_q;
        b_valid_d   = b_valid_q;
        b_resp_d    = b_resp_q;
        wr_en       = 1'b0;
        case (wr_state_q)
            W_IDLE: begin
                if (aw_valid && aw_ready_q) begin
                    wr_addr_d   = write_addr;
                    have_addr_d = 1'b1;
                end
                if (w_valid && w_ready_q) begin
                    wr_data_d   = write_data;
                    have_data_d = 1'b1;
                end
                if (have_addr_d && have_data_d) begin
                    have_addr_d = 1'b0;
                    have_data_d = 1'b0;
                    aw_ready_d  = 1'b0;
                    w_ready_d   = 1'b0;
                    wr_state_d  = W_COMMIT;
                end else begin
                    aw_ready_d = !have_addr_d;
                    w_ready_d  = !have_data_d;
                end
            end
            W_COMMIT: begin
                wr_en      = wr_in_range;
                b_resp_d   = wr_in_range ? RESP_WDTH'(RESP_OKAY) : RESP_WDTH'(RESP_ERR);
                wr_state_d = W_RESP;
            end
            W_RESP: begin
                if (b_valid_q && b_ready) begin
                    b_valid_d  = 1'b0;
                    aw_ready_d = 1'b1;
                    w_ready_d  = 1'b1;
                    wr_state_d = W_IDLE;
                end else begin
                    b_valid_d = 1'b1;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state_q  <= R_IDLE;
            rd_addr_q   <= '0;
            rd_cnt_q    <= '0;
            ar_ready_q  <= 1'b0;
            r_valid_q   <= 1'b0;
            r_data_q    <= '0;
            r_resp_q    <= '0;
            wr_state_q  <= W_IDLE;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            have_addr_q <= 1'b0;
            have_data_q <= 1'b0;
            aw_ready_q  <= 1'b0;
            w_ready_q   <= 1'b0;
            b_valid_q   <= 1'b0;
            b_resp_q    <= '0;
        end else begin
            rd_state_q  <= rd_state_d;
            rd_addr_q   <= rd_addr_d;
            rd_cnt_q    <= rd_cnt_d;
            ar_ready_q  <= ar_ready_d;
            r_valid_q   <= r_valid_d;
            r_data_q    <= r_data_d;
            r_resp_q    <= r_resp_d;
            wr_state_q  <= wr_state_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            have_addr_q <= have_addr_d;
            have_data_q <= have_data_d;
            aw_ready_q  <= aw_ready_d;
            w_ready_q   <= w_ready_d;
            b_valid_q   <= b_valid_d;
            b_resp_q    <= b_resp_d;
        end
    end

    assign ar_ready = ar_ready_q;
    assign r_valid  = r_valid_q;
    assign r_data   = r_data_q;
    assign r_resp   = r_resp_q;
    assign aw_ready = aw_ready_q;
    assign w_ready  = w_ready_q;
    assign b_valid  = b_valid_q;
    assign b_resp   = b_resp_q;

endmodule

// File: tb/tb_sort_mem_responder.sv
// Scoreboard bench for sort_mem_responder: a DEPTH=10 instance for function and
// range checks, plus READ_LAT=0 and READ_LAT=7 instances for read timing.
module tb_sort_mem_responder;

    localparam int MAIN_LAT = 1;

    typedef struct {
        logic [31:0] data;
        logic        resp;
        int          cyc;
    } r_exp_t;

    typedef struct {
        logic resp;
        int   cyc;
    } b_exp_t;

    typedef struct {
        bit          is_wr;
        logic [3:0]  addr;
        logic [31:0] data;
        int          lead;
        logic        resp;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        ar_valid, ar_ready, r_valid, r_ready;
    logic [3:0]  ar_address, write_addr;
    logic [31:0] r_data, write_data;
    logic [0:0]  r_resp, b_resp;
    logic        aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;

    logic        lat_ar_valid [2];
    logic        lat_ar_ready [2];
    logic        lat_r_valid  [2];
    logic [31:0] lat_r_data   [2];
    logic [0:0]  lat_r_resp   [2];
    logic        lat_aw_ready [2];
    logic        lat_w_ready  [2];
    logic        lat_b_valid  [2];
    logic [0:0]  lat_b_resp   [2];
    logic [3:0]  lat_addr  = 4'd0;
    logic [31:0] lat_wdata = 32'd0;
    logic        lat_lo    = 1'b0;
    logic        lat_hi    = 1'b1;

    int     cyc = 0;
    int     total = 0;
    int     passed = 0;
    r_exp_t rdq[$];
    b_exp_t wrq[$];
    r_exp_t curR;
    bit     haveCur = 0;
    bit     rPrev = 0;
    bit     bPrev = 0;
    vec_t   vecs[10];

    sort_mem_responder #(.ADDR_WDTH(4), .DATA_WDTH(32), .RESP_WDTH(1), .DEPTH(10), .READ_LAT(MAIN_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_address(ar_address),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .write_addr(write_addr),
        .w_valid(w_valid), .w_ready(w_ready), .write_data(write_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp)
    );

    sort_mem_responder #(.ADDR_WDTH(4), .DATA_WDTH(32), .RESP_WDTH(1), .DEPTH(16), .READ_LAT(0)) dut_lat0 (
        .clk(clk), .rst_n(rst_n),
        .ar_valid(lat_ar_valid[0]), .ar_ready(lat_ar_ready[0]), .ar_address(lat_addr),
        .r_valid(lat_r_valid[0]), .r_ready(lat_hi), .r_data(lat_r_data[0]), .r_resp(lat_r_resp[0]),
        .aw_valid(lat_lo), .aw_ready(lat_aw_ready[0]), .write_addr(lat_addr),
        .w_valid(lat_lo), .w_ready(lat_w_ready[0]), .write_data(lat_wdata),
        .b_valid(lat_b_valid[0]), .b_ready(lat_hi), .b_resp(lat_b_resp[0])
    );

    sort_mem_responder #(.ADDR_WDTH(4), .DATA_WDTH(32), .RESP_WDTH(1), .DEPTH(16), .READ_LAT(7)) dut_lat7 (
        .clk(clk), .rst_n(rst_n),
        .ar_valid(lat_ar_valid[1]), .ar_ready(lat_ar_ready[1]), .ar_address(lat_addr),
        .r_valid(lat_r_valid[1]), .r_ready(lat_hi), .r_data(lat_r_data[1]), .r_resp(lat_r_resp[1]),
        .aw_valid(lat_lo), .aw_ready(lat_aw_ready[1]), .write_addr(lat_addr),
        .w_valid(lat_lo), .w_ready(lat_w_ready[1]), .write_data(lat_wdata),
        .b_valid(lat_b_valid[1]), .b_ready(lat_hi), .b_resp(lat_b_resp[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic reportFail(input string name);
        total++;
        $display("[TB] FAIL %s: got timeout/unexpected event, expected completion", name);
    endtask

    // Monitor: pops the scoreboard when the DUT presents a response, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            rPrev   = 1'b0;
            bPrev   = 1'b0;
            haveCur = 1'b0;
        end else begin
            if (r_valid && !rPrev) begin
                if (rdq.size() == 0) begin
                    reportFail("r_unexpected");
                end else begin
                    curR    = rdq.pop_front();
                    haveCur = 1'b1;
                    checkOutput("r_latency", 32'(cyc), 32'(curR.cyc));
                end
            end
            if (r_valid && r_ready && haveCur) begin
                checkOutput("r_data", r_data, curR.data);
                checkOutput("r_resp", 32'(r_resp), 32'(curR.resp));
                haveCur = 1'b0;
            end
            if (b_valid && !bPrev) begin
                if (wrq.size() == 0) begin
                    reportFail("b_unexpected");
                end else begin
                    b_exp_t e;
                    e = wrq.pop_front();
                    checkOutput("b_latency", 32'(cyc), 32'(e.cyc));
                    checkOutput("b_resp", 32'(b_resp), 32'(e.resp));
                end
            end
            rPrev = r_valid;
            bPrev = b_valid;
        end
    end

    task automatic applyWrite(input logic [3:0] a, input logic [31:0] d, input int lead, input logic resp);
        bit awDone, wDone, fireAw, fireW;
        int n;
        awDone = 0; wDone = 0; n = 0;
        write_addr = a;
        write_data = d;
        w_valid    = 1'b1;
        while (!(awDone && wDone) && n < 40) begin
            if (n == lead) aw_valid = 1'b1;
            @(negedge clk);
            fireAw = aw_valid && aw_ready;
            fireW  = w_valid && w_ready;
            @(posedge clk); #1;
            if (fireAw) begin aw_valid = 1'b0; awDone = 1; end
            if (fireW)  begin w_valid  = 1'b0; wDone  = 1; end
            n++;
        end
        if (awDone && wDone) wrq.push_back('{resp: resp, cyc: cyc + 2});
        else begin
            aw_valid = 1'b0;
            w_valid  = 1'b0;
            reportFail("write_handshake");
        end
    endtask

    task automatic applyRead(input logic [3:0] a, input logic [31:0] d, input logic resp, input bit doPush);
        bit fire;
        int n;
        fire = 0; n = 0;
        ar_address = a;
        ar_valid   = 1'b1;
        while (!fire && n < 40) begin
            @(negedge clk);
            fire = ar_valid && ar_ready;
            @(posedge clk); #1;
            n++;
        end
        ar_valid = 1'b0;
        if (!fire) reportFail("read_handshake");
        else if (doPush) rdq.push_back('{data: d, resp: resp, cyc: cyc + 1 + MAIN_LAT});
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((rdq.size() != 0 || wrq.size() != 0 || haveCur || r_valid || b_valid) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) reportFail("drain");
    endtask

    task automatic applyStimulus(input vec_t v);
        if (v.is_wr) applyWrite(v.addr, v.data, v.lead, v.resp);
        else applyRead(v.addr, v.data, v.resp, 1'b1);
        drain();
    endtask

    // Holds ar_valid high with r_ready tied high and measures first latency and accept period.
    task automatic measureLatency(input int idx, input int lat);
        int  acc[3];
        int  rise, nAcc;
        bit  prevV;
        rise = -1; nAcc = 0; prevV = 0;
        lat_ar_valid[idx] = 1'b1;
        for (int n = 0; n < 80 && nAcc < 3; n++) begin
            @(negedge clk);
            if (lat_r_valid[idx] && !prevV && rise < 0) rise = cyc;
            prevV = lat_r_valid[idx];
            if (lat_ar_valid[idx] && lat_ar_ready[idx]) begin
                acc[nAcc] = cyc + 1;
                nAcc++;
            end
        end
        @(posedge clk); #1;
        lat_ar_valid[idx] = 1'b0;
        if (nAcc < 3 || rise < 0) reportFail($sformatf("lat%0d_progress", lat));
        else begin
            checkOutput($sformatf("lat%0d_first_rvalid", lat), 32'(rise - acc[0]), 32'(lat + 1));
            checkOutput($sformatf("lat%0d_period_a", lat), 32'(acc[1] - acc[0]), 32'(lat + 3));
            checkOutput($sformatf("lat%0d_period_b", lat), 32'(acc[2] - acc[1]), 32'(lat + 3));
        end
        repeat (12) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{1'b1, 4'd3,  32'hFFFF_FFF9, 0, 1'b0};
        vecs[1] = '{1'b0, 4'd3,  32'hFFFF_FFF9, 0, 1'b0};
        vecs[2] = '{1'b1, 4'd5,  32'd42,        3, 1'b0};
        vecs[3] = '{1'b0, 4'd5,  32'd42,        0, 1'b0};
        vecs[4] = '{1'b0, 4'd15, 32'd0,         0, 1'b1};
        vecs[5] = '{1'b1, 4'd12, 32'hDEAD_BEEF, 0, 1'b1};
        vecs[6] = '{1'b0, 4'd2,  32'd0,         0, 1'b0};
        vecs[7] = '{1'b0, 4'd4,  32'd0,         0, 1'b0};
        vecs[8] = '{1'b0, 4'd3,  32'hFFFF_FFF9, 0, 1'b0};
        vecs[9] = '{1'b1, 4'd0,  32'd9,         0, 1'b0};

        rst_n = 1'b1;
        ar_valid = 1'b0; ar_address = '0; r_ready = 1'b1;
        aw_valid = 1'b0; write_addr = '0; w_valid = 1'b0; write_data = '0; b_ready = 1'b1;
        lat_ar_valid[0] = 1'b0;
        lat_ar_valid[1] = 1'b0;
        #2 rst_n = 1'b0;
        #3;
        checkOutput("rst_ar_ready", 32'(ar_ready), 32'd0);
        checkOutput("rst_aw_ready", 32'(aw_ready), 32'd0);
        checkOutput("rst_w_ready",  32'(w_ready),  32'd0);
        checkOutput("rst_r_valid",  32'(r_valid),  32'd0);
        checkOutput("rst_b_valid",  32'(b_valid),  32'd0);
        checkOutput("rst_r_data",   r_data,        32'd0);
        checkOutput("rst_r_resp",   32'(r_resp),   32'd0);
        checkOutput("rst_b_resp",   32'(b_resp),   32'd0);
        #17 rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("post_rst_ar_ready", 32'(ar_ready), 32'd1);
        checkOutput("post_rst_aw_ready", 32'(aw_ready), 32'd1);
        checkOutput("post_rst_w_ready",  32'(w_ready),  32'd1);

        for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);

        // Read of addr 0 stalls on r_ready while a write of 1 commits on the capture edge.
        r_ready = 1'b0;
        applyRead(4'd0, 32'd9, 1'b0, 1'b1);
        applyWrite(4'd0, 32'd1, 0, 1'b0);
        repeat (4) @(posedge clk);
        #1 r_ready = 1'b1;
        drain();
        applyStimulus('{1'b0, 4'd0, 32'd1, 0, 1'b0});

        // Reset while the read waits and the write response is pending.
        b_ready = 1'b0;
        applyWrite(4'd3, 32'h0000_0077, 0, 1'b0);
        for (int n = 0; n < 20 && !b_valid; n++) begin
            @(posedge clk); #1;
        end
        applyRead(4'd3, 32'd0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_ar_ready", 32'(ar_ready), 32'd0);
        checkOutput("midrst_r_valid",  32'(r_valid),  32'd0);
        checkOutput("midrst_aw_ready", 32'(aw_ready), 32'd0);
        checkOutput("midrst_w_ready",  32'(w_ready),  32'd0);
        checkOutput("midrst_b_valid",  32'(b_valid),  32'd0);
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        b_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("rerst_ar_ready", 32'(ar_ready), 32'd1);
        checkOutput("rerst_aw_ready", 32'(aw_ready), 32'd1);
        applyStimulus('{1'b0, 4'd3, 32'd0, 0, 1'b0});

        measureLatency(0, 0);
        measureLatency(1, 7);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
